// File: rtl/axi_lite_write_slave.sv
// AXI4-Lite write responder committing byte-strobed data into a register bank.
// Latency: BVALID rises one cycle after the later of the AW and W handshakes.
// Backpressure: AWREADY/WREADY drop while a payload is held or a B response is pending.
//
// Ports:
//   ACLK, ARESET          clock / async active-low reset
//   AW*, W*, B*           AXI4-Lite write address, data and response channels
//   rd_idx_i -> rd_data   combinational side read of bank[rd_idx]
//   wr_pulse, wr_idx      one-cycle strobe and index of each OKAY commit
module axi_lite_write_slave #(
  parameter int unsigned NUM_REGS  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic                        AWVALID,
  output logic                        AWREADY,
  input  logic [31:0]                 AWADDR,
  input  logic                        WVALID,
  output logic                        WREADY,
  input  logic [31:0]                 WDATA,
  input  logic [3:0]                  WSTRB,
  output logic                        BVALID,
  input  logic                        BREADY,
  output logic [1:0]                  BRESP,
  input  logic [$clog2(NUM_REGS)-1:0] rd_idx,
  output logic [31:0]                 rd_data,
  output logic                        wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0] wr_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMMIT,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic              aw_full_q, aw_full_d;
  logic              w_full_q, w_full_d;
  logic [31:2]       awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              wr_pulse_q, wr_pulse_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [31:0]       bank_q [NUM_REGS];
  logic [31:0]       bank_d [NUM_REGS];

  logic              aw_hs, w_hs;
  logic [29:0]       word_off;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              unused_addr_lsbs;

  // Byte offset inside a word is irrelevant to register selection.
  assign unused_addr_lsbs = ^AWADDR[1:0];

  assign BVALID  = (state_q == S_RESP);
  assign AWREADY = !aw_full_q && !BVALID && ARESET;
  assign WREADY  = !w_full_q && !BVALID && ARESET;
  assign BRESP   = bresp_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_idx   = wr_idx_q;
  assign rd_data  = bank_q[rd_idx];

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;

  // BASE_ADDR is word aligned, so subtracting word addresses wraps exactly like
  // the 32-bit byte subtraction shifted right by two; an address below the base
  // wraps to a huge offset and falls out of range.
  assign word_off = awaddr_q[31:2] - BASE_ADDR[31:2];
  assign in_range = (word_off < 30'(NUM_REGS));
  assign idx      = word_off[IDX_W-1:0];

  always_comb begin
    state_d    = state_q;
    aw_full_d  = aw_full_q;
    w_full_d   = w_full_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    wr_pulse_d = 1'b0;
    wr_idx_d   = wr_idx_q;
    bank_d     = bank_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      awaddr_d  = AWADDR[31:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = WDATA;
      wstrb_d  = WSTRB;
    end

    case (state_q)
      S_IDLE: begin
        // Move on as soon as both halves are (or are about to be) held.
        if (aw_full_d && w_full_d) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        aw_full_d = 1'b0;
        w_full_d  = 1'b0;
        state_d   = S_RESP;
        if (in_range) begin
          bresp_d    = RESP_OKAY;
          wr_pulse_d = 1'b1;
          wr_idx_d   = idx;
          for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) bank_d[idx][8*b +: 8] = wdata_q[8*b +: 8];
          end
        end else begin
          bresp_d = RESP_SLVERR;
        end
      end
      S_RESP: begin
        if (BREADY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state_q    <= S_IDLE;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= 1'b0;
      wr_idx_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      aw_full_q  <= aw_full_d;
      w_full_q   <= w_full_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      wr_idx_q   <= wr_idx_d;
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= bank_d[i];
    end
  end

endmodule

// File: tb/tb_axi_lite_write_slave.sv
// Testbench for axi_lite_write_slave: directed and randomized writes against a
// byte-lane register-bank model; handshake timing checked cycle by cycle.
module tb_axi_lite_write_slave;

  localparam int          NREG = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [31:0] AWADDR, WDATA, rd_data;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP;
  logic [3:0]  rd_idx, wr_idx;
  logic        wr_pulse;

  int checks = 0;
  int failures = 0;
  int aw_cnt = 0;
  int b_cnt = 0;
  logic [31:0] model [NREG];

  axi_lite_write_slave #(.NUM_REGS(NREG), .BASE_ADDR(BASE)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .rd_idx(rd_idx), .rd_data(rd_data),
    .wr_pulse(wr_pulse), .wr_idx(wr_idx)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    if (ARESET && AWVALID && AWREADY) aw_cnt <= aw_cnt + 1;
    if (ARESET && BVALID && BREADY) b_cnt <= b_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: byte offset from the base, word index, byte-lane merge.
  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output bit okay, output int idx);
    logic [31:0] off;
    off  = addr - BASE;
    okay = ((off / 4) < NREG);
    idx  = int'(off / 4);
    if (okay) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    end else begin
      idx = 0;
    end
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < NREG; i++) begin
      rd_idx = 4'(i);
      #1;
      chk($sformatf("%s rd_data[%0d]", tag, i), rd_data, model[i]);
    end
    @(negedge ACLK);
  endtask

  // Entered and left on a falling edge. b_dly<0 keeps BREADY high from the start.
  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input int b_dly);
    bit okay;
    int idx;
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_hs, w_hs;
    int cyc = 0;
    model_write(addr, data, strb, okay, idx);
    if (b_dly < 0) BREADY = 1'b1;
    while (!(aw_done && w_done)) begin
      if (cyc >= 200) begin
        checks++;
        failures++;
        $error("FAIL %s handshake_timeout observed_cycles=%0d required<200", tag, cyc);
        break;
      end
      AWVALID = !aw_done && (cyc >= aw_dly);
      AWADDR  = addr;
      WVALID  = !w_done && (cyc >= w_dly);
      WDATA   = data;
      WSTRB   = strb;
      #1;
      if (w_done && !aw_done) chk({tag, " WREADY held low"}, WREADY, 0);
      if (aw_done && !w_done) chk({tag, " AWREADY held low"}, AWREADY, 0);
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      @(negedge ACLK);
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      cyc++;
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    #1;
    chk({tag, " BVALID low at capture"}, BVALID, 0);
    chk({tag, " AWREADY low at capture"}, AWREADY, 0);
    @(negedge ACLK);
    chk({tag, " BVALID"}, BVALID, 1);
    chk({tag, " BRESP"}, BRESP, okay ? 32'd0 : 32'd2);
    chk({tag, " wr_pulse"}, wr_pulse, okay);
    if (okay) chk({tag, " wr_idx"}, wr_idx, idx);
    if (b_dly > 0) begin
      BREADY = 1'b0;
      for (int i = 0; i < b_dly; i++) begin
        @(negedge ACLK);
        chk({tag, " BVALID held"}, BVALID, 1);
        chk({tag, " BRESP held"}, BRESP, okay ? 32'd0 : 32'd2);
        chk({tag, " AWREADY in resp"}, AWREADY, 0);
        chk({tag, " WREADY in resp"}, WREADY, 0);
        chk({tag, " wr_pulse one cycle"}, wr_pulse, 0);
      end
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    chk({tag, " BVALID cleared"}, BVALID, 0);
    chk({tag, " wr_pulse cleared"}, wr_pulse, 0);
    chk({tag, " AWREADY after B"}, AWREADY, 1);
    chk({tag, " WREADY after B"}, WREADY, 1);
  endtask

  initial begin
    int aw0, b0;
    AWVALID = 0; WVALID = 0; BREADY = 0;
    AWADDR = '0; WDATA = '0; WSTRB = '0; rd_idx = '0;
    for (int i = 0; i < NREG; i++) model[i] = '0;

    // Reset state
    repeat (2) @(negedge ACLK);
    chk("reset AWREADY", AWREADY, 0);
    chk("reset WREADY", WREADY, 0);
    chk("reset BVALID", BVALID, 0);
    chk("reset BRESP", BRESP, 0);
    chk("reset wr_pulse", wr_pulse, 0);
    chk("reset wr_idx", wr_idx, 0);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("release AWREADY", AWREADY, 1);
    chk("release WREADY", WREADY, 1);
    check_bank("reset");

    // AW and W together, BREADY already high
    do_write("t1", BASE + 32'h08, 32'hDEADBEEF, 4'hF, 0, 0, -1);
    rd_idx = 4'd2; #1;
    chk("t1 rd_data[2]", rd_data, 32'hDEADBEEF);
    @(negedge ACLK);

    // W three cycles ahead of AW, partial strobe
    do_write("t2 preload", BASE + 32'h04, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    do_write("t2", BASE + 32'h04, 32'h11223344, 4'b0101, 3, 0, 0);
    rd_idx = 4'd1; #1;
    chk("t2 rd_data[1]", rd_data, 32'hAA22CC44);
    @(negedge ACLK);

    // Out-of-range addresses, above the bank and below the base
    do_write("t3 above", BASE + 32'(4 * NREG), $urandom, 4'hF, 1, 0, 0);
    do_write("t3 below", BASE - 32'd4, $urandom, 4'hF, 0, 2, 0);
    check_bank("t3");

    // Slow BREADY, then an immediate follow-on write
    do_write("t4 slow B", BASE + 32'h0C, $urandom, 4'hF, 1, 2, 5);
    do_write("t4 next", BASE + 32'h10, $urandom, 4'b0011, 0, 0, 0);
    do_write("t4 zero strb", BASE + 32'h10, $urandom, 4'b0000, 0, 1, 0);
    check_bank("t4");

    // Reset between AW and W: transaction dropped, bank cleared
    AWVALID = 1'b1; AWADDR = BASE + 32'h14; #1;
    chk("t5 AWREADY", AWREADY, 1);
    @(negedge ACLK);
    AWVALID = 1'b0; #1;
    chk("t5 AWREADY after capture", AWREADY, 0);
    ARESET = 1'b0; #1;
    chk("t5 AWREADY in reset", AWREADY, 0);
    chk("t5 WREADY in reset", WREADY, 0);
    @(negedge ACLK);
    ARESET = 1'b1;
    for (int i = 0; i < NREG; i++) model[i] = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("t5 no B after reset", BVALID, 0);
    end
    check_bank("t5");
    do_write("t5 fresh", BASE + 32'h14, 32'hCAFEF00D, 4'hF, 0, 0, 0);

    // Back-to-back writes over every index, then random addresses
    aw0 = aw_cnt; b0 = b_cnt;
    for (int i = 0; i < NREG; i++)
      do_write($sformatf("t6 idx%0d", i), BASE + 32'(4 * i) + 32'($urandom_range(0, 3)),
               $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 4));
    check_bank("t6 seq");
    for (int i = 0; i < 20; i++)
      do_write($sformatf("t6 rnd%0d", i), BASE + 32'($urandom_range(0, 4 * NREG + 15)),
               $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3));
    check_bank("t6 rnd");
    chk("t6 AW count", aw_cnt - aw0, NREG + 20);
    chk("t6 B count", b_cnt - b0, NREG + 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
